// File: rtl/ysyx_22050710_dsram_responder_pkg.sv
// Shared definitions for the data-SRAM interface: transfer-size codes, bus widths
// and the alignment helper used by the execute/memory stages and the responder.
package ysyx_22050710_dsram_responder_pkg;

    localparam int DSRAM_ADDR_WD  = 32;
    localparam int DSRAM_DATA_WD  = 64;
    localparam int DSRAM_WMASK_WD = DSRAM_DATA_WD / 8;

    // Per-entry response age; wide enough for the largest supported latency (15).
    localparam int AGE_WD = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } sram_size_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return (addr_lo & mask) != 3'd0;
    endfunction

endpackage

// File: rtl/ysyx_22050710_dsram_responder_resp_fifo.sv
// In-order response queue: each entry holds {wr, rdata} plus an age counter that
// saturates at RESP_LAT; the head is ready once it has aged RESP_LAT cycles.
module ysyx_22050710_resp_fifo
    import ysyx_22050710_dsram_responder_pkg::*;
#(
    parameter int QDEPTH   = 2,
    parameter int DW       = 64,
    parameter int RESP_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          push,
    input  logic          push_wr,
    input  logic [DW-1:0] push_rdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic          head_ready,
    output logic          head_wr,
    output logic [DW-1:0] head_rdata
);

    localparam int PW = $clog2(QDEPTH);

    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [PW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    logic                              wr_mem    [QDEPTH];
    logic [DW-1:0]                     rdata_mem [QDEPTH];
    logic [QDEPTH-1:0][AGE_WD-1:0]     age_all;

    assign full    = (count_reg == QDEPTH[PW:0]);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + 1'b1;
            if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            wr_mem[wptr_reg]    <= push_wr;
            rdata_mem[wptr_reg] <= push_rdata;
        end
    end

    // The acceptance edge counts as the first cycle of age, so RESP_LAT=1
    // makes an entry ready in the very next cycle.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
        logic [AGE_WD-1:0] age_reg;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                age_reg <= '0;
            end else if (push_ok && (wptr_reg == PW'(gi))) begin
                age_reg <= AGE_WD'(1);
            end else if (age_reg < AGE_WD'(RESP_LAT)) begin
                age_reg <= age_reg + 1'b1;
            end
        end
        assign age_all[gi] = age_reg;
    end

    assign head_ready = !empty && (age_all[rptr_reg] >= AGE_WD'(RESP_LAT));
    assign head_wr    = wr_mem[rptr_reg];
    assign head_rdata = rdata_mem[rptr_reg];

endmodule

// File: rtl/ysyx_22050710_dsram_responder.sv
// Data-SRAM slave model: word array with byte-strobe writes, read data captured at
// acceptance, and in-order responses delayed by at least RESP_LAT cycles.
module ysyx_22050710_dsram_responder
    import ysyx_22050710_dsram_responder_pkg::*;
#(
    parameter int SRAM_ADDR_WD  = DSRAM_ADDR_WD,
    parameter int SRAM_DATA_WD  = DSRAM_DATA_WD,
    parameter int SRAM_WMASK_WD = DSRAM_WMASK_WD,
    parameter int MEM_AW        = 12,
    parameter int RESP_LAT      = 1,
    parameter int QDEPTH        = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_data_sram_req,
    input  logic                     i_data_sram_wr,
    input  logic [1:0]               i_data_sram_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
    output logic                     o_data_sram_addr_ok,
    output logic                     o_data_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
    input  logic                     i_resp_stall
);

    localparam int MEM_DEPTH = 1 << MEM_AW;

    logic [SRAM_DATA_WD-1:0] mem_array [MEM_DEPTH];

    logic [MEM_AW-1:0]       word_idx;
    logic [SRAM_DATA_WD-1:0] rd_word;
    logic [SRAM_DATA_WD-1:0] merged_word;
    logic                    fire;
    logic                    wr_fire;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head_ready;
    logic                    head_wr;
    logic [SRAM_DATA_WD-1:0] head_rdata;
    logic                    unused_bits;

    // Byte offset and bits above the array index are dropped, so addresses alias.
    assign word_idx = i_data_sram_addr[MEM_AW+2:3];
    assign rd_word  = mem_array[word_idx];

    assign o_data_sram_addr_ok = i_data_sram_req && !fifo_full;
    assign fire                = o_data_sram_addr_ok;
    assign wr_fire             = fire && i_data_sram_wr;

    for (genvar gi = 0; gi < SRAM_WMASK_WD; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = i_data_sram_wstrb[gi] ? i_data_sram_wdata[8*gi +: 8]
                                                              : rd_word[8*gi +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem_array[word_idx] <= merged_word;
        end
    end

    ysyx_22050710_resp_fifo #(
        .QDEPTH  (QDEPTH),
        .DW      (SRAM_DATA_WD),
        .RESP_LAT(RESP_LAT)
    ) u_resp_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (fire),
        .push_wr   (i_data_sram_wr),
        .push_rdata(i_data_sram_wr ? '0 : rd_word),
        .pop       (o_data_sram_data_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_ready(head_ready),
        .head_wr   (head_wr),
        .head_rdata(head_rdata)
    );

    assign o_data_sram_data_ok = head_ready && !i_resp_stall;
    assign o_data_sram_rdata   = (o_data_sram_data_ok && !head_wr) ? head_rdata : '0;

    assign unused_bits = ^{i_data_sram_addr[SRAM_ADDR_WD-1:MEM_AW+3], i_data_sram_addr[2:0],
                           i_data_sram_size, fifo_empty};

`ifndef SYNTHESIS
    a_no_fire_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(fire && fifo_full));

    a_write_strobe: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        wr_fire |-> (i_data_sram_wstrb != '0))
        else $warning("dsram write accepted with empty byte strobe");

    a_alignment: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        fire |-> !misaligned(i_data_sram_size, i_data_sram_addr[2:0]))
        else $warning("dsram request misaligned for its size");
`endif

endmodule
